// File: rtl/handshake_fifo_buffer_if.sv
// Valid/ready channel bundle for the elastic FIFO buffer: the upstream token
// stream (ins*), the downstream head stream (outs*) and the occupancy count.
interface handshake_fifo_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // A token moves on a rising edge exactly when valid && ready on that side.
    // A producer that raised valid keeps data/valid stable until ready; ready
    // may come and go freely and never depends combinationally on valid.
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;
    logic [CW-1:0]         count;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid, count
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid, count
    );
endinterface

// File: rtl/handshake_fifo_buffer.sv
// Elastic FIFO buffer between dataflow units: DEPTH registered slots, explicit
// pointer wrap so any DEPTH in 2..64 works, all handshake outputs registered-state only.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic clk,
    input logic rst,
    handshake_fifo_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [CW-1:0]         cnt;
    logic                  not_full;
    logic                  not_empty;
    logic                  push;
    logic                  pop;

    assign not_full  = (cnt != FULL);
    assign not_empty = (cnt != '0);

    // No pass-through when full and no bypass when empty: both sides see only cnt.
    assign push = rst && bus.ins_valid && not_full;
    assign pop  = rst && bus.outs_ready && not_empty;

    assign bus.ins_ready  = not_full;
    assign bus.outs_valid = not_empty;
    assign bus.outs       = not_empty ? mem[rp] : '0;
    assign bus.count      = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= bus.ins;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= (wp == LAST) ? '0 : wp + PW'(1);
            end
            if (pop) begin
                rp <= (rp == LAST) ? '0 : rp + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed bench for the FIFO buffer (DEPTH=4) plus a random-handshake
// scoreboard run on a DEPTH=3, 37-bit instance.
module tb_handshake_fifo_buffer;
    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    handshake_fifo_buffer_if #(.DATA_WIDTH(32), .DEPTH(4)) bus_a ();
    handshake_fifo_buffer_if #(.DATA_WIDTH(37), .DEPTH(3)) bus_b ();

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    handshake_fifo_buffer #(.DATA_WIDTH(37), .DEPTH(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver helpers: inputs change at the falling edge, outputs checked there too
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d, input logic r);
        bus_a.ins_valid  = v;
        bus_a.ins        = d;
        bus_a.outs_ready = r;
    endtask

    task automatic check_a(input string tag, input logic v, input logic [31:0] d,
                           input logic [2:0] c, input logic ir);
        check({tag, "_valid"}, 64'(bus_a.outs_valid), 64'(v));
        check({tag, "_outs"},  64'(bus_a.outs),       64'(d));
        check({tag, "_count"}, 64'(bus_a.count),      64'(c));
        check({tag, "_ready"}, 64'(bus_a.ins_ready),  64'(ir));
    endtask

    // scoreboard for the random run
    localparam logic [36:0] PAT = 37'h0D7569F4B0;
    logic [36:0] exp_q[$];

    initial begin
        int sent;
        int got;
        int cyc;
        logic [36:0] head;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive_a(1'b1, 32'hDEAD_BEEF, 1'b1);
        bus_b.ins_valid  = 1'b1;
        bus_b.ins        = '1;
        bus_b.outs_ready = 1'b1;

        @(negedge clk);
        check_a("reset", 1'b0, 32'h0, 3'd0, 1'b1);
        step();
        check_a("reset_hold", 1'b0, 32'h0, 3'd0, 1'b1);
        check("reset_b_count", 64'(bus_b.count), 64'd0);
        drive_a(1'b0, 32'h0, 1'b0);
        bus_b.ins_valid  = 1'b0;
        bus_b.outs_ready = 1'b0;
        rst = 1'b1;
        step();

        // fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'hA1 + 32'(i), 1'b0);
            step();
        end
        check_a("full", 1'b1, 32'hA1, 3'd4, 1'b0);
        drive_a(1'b1, 32'hA5, 1'b0);
        step();
        step();
        check_a("full_hold", 1'b1, 32'hA1, 3'd4, 1'b0);

        // drain one per cycle
        drive_a(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_outs%0d", i), 64'(bus_a.outs), 64'(32'hA1 + 32'(i)));
            check($sformatf("drain_count%0d", i), 64'(bus_a.count), 64'(4 - i));
            step();
        end
        check_a("drained", 1'b0, 32'h0, 3'd0, 1'b1);

        // streaming through the buffer wraps the pointers five times
        drive_a(1'b1, 32'd1, 1'b1);
        check("no_bypass", 64'(bus_a.outs_valid), 64'd0);
        step();
        for (int k = 1; k <= 20; k++) begin
            check($sformatf("stream_outs%0d", k), 64'(bus_a.outs), 64'(k));
            check($sformatf("stream_count%0d", k), 64'(bus_a.count), 64'd1);
            if (k < 20) bus_a.ins = 32'(k + 1);
            else        bus_a.ins_valid = 1'b0;
            step();
        end
        check_a("stream_end", 1'b0, 32'h0, 3'd0, 1'b1);

        // push and pop offered together while full: only the pop happens
        drive_a(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'hB1 + 32'(i), 1'b0);
            step();
        end
        check_a("full2", 1'b1, 32'hB1, 3'd4, 1'b0);
        drive_a(1'b1, 32'hB5, 1'b1);
        step();
        check_a("full_pushpop", 1'b1, 32'hB2, 3'd3, 1'b1);

        // asynchronous reset with three tokens stored
        drive_a(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        #1 check_a("async_reset", 1'b0, 32'h0, 3'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_a("post_reset", 1'b0, 32'h0, 3'd0, 1'b1);
        drive_a(1'b1, 32'h15, 1'b0);
        step();
        check_a("first_push", 1'b1, 32'h15, 3'd1, 1'b1);
        drive_a(1'b0, 32'h0, 1'b1);
        step();
        check_a("first_pop", 1'b0, 32'h0, 3'd0, 1'b1);
        drive_a(1'b0, 32'h0, 1'b0);

        // random valid/ready on the DEPTH=3 instance
        sent = 0;
        got  = 0;
        bus_b.ins_valid  = 1'b0;
        bus_b.outs_ready = 1'b0;
        for (cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            check("rand_count", 64'(bus_b.count), 64'(exp_q.size()));
            check("rand_valid", 64'(bus_b.outs_valid), 64'(exp_q.size() != 0));
            check("rand_ready", 64'(bus_b.ins_ready), 64'(exp_q.size() != 3));
            if (!bus_b.ins_valid && sent < 1000) begin
                bus_b.ins       = PAT ^ 37'(sent);
                bus_b.ins_valid = 1'($urandom_range(0, 1));
            end
            bus_b.outs_ready = 1'($urandom_range(0, 1));
            if (bus_b.outs_valid && bus_b.outs_ready) begin
                head = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("rand_data", 64'(bus_b.outs), 64'(head));
                got++;
            end
            if (bus_b.ins_valid && bus_b.ins_ready) begin
                exp_q.push_back(bus_b.ins);
                sent++;
            end
            step();
            if (bus_b.ins_valid && exp_q.size() != 0 && exp_q[$] == bus_b.ins) begin
                bus_b.ins_valid = 1'b0;
            end
        end
        check("rand_received", 64'(got), 64'd1000);
        check("rand_leftover", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
